// File: rtl/sample_pwm_out.sv
// Audio sink: buffers signed samples in a small FIFO and plays one per PWM period.
// Optional build macro UNDERRUN_MUTE_EN: on underrun load midscale instead of holding duty.
module sample_pwm_out #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  pwm_out,
  output logic                  underrun,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [WIDTH-1:0] Midscale = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [WIDTH-1:0]      cnt_q;
  logic [WIDTH-1:0]      duty_q;
  logic                  pwm_q;
  logic                  underrun_q;
  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;

  logic                  boundary;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [WIDTH-1:0]      head_duty;

  always_comb begin
    boundary     = (cnt_q == {WIDTH{1'b1}});
    fifo_empty   = (level_q == '0);
    sample_ready = (level_q != LevelFull);
    push         = sample_valid && sample_ready;
    pop          = boundary && !fifo_empty;
    // Offset binary: flipping the sign bit maps signed range onto 0..2**WIDTH-1.
    head_duty    = {~mem_q[rd_ptr_q][WIDTH-1], mem_q[rd_ptr_q][WIDTH-2:0]};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      duty_q     <= Midscale;
      pwm_q      <= 1'b0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      cnt_q      <= cnt_q + 1'b1;
      pwm_q      <= (cnt_q < duty_q);
      underrun_q <= boundary && fifo_empty;

      if (pop) begin
        duty_q <= head_duty;
      end else if (boundary) begin
`ifdef UNDERRUN_MUTE_EN
        duty_q <= Midscale;
`else
        duty_q <= duty_q;
`endif
      end

      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign pwm_out    = pwm_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;

endmodule
